ysyx_24110026_alu_arbiter: RTL and testbench
============================================

// Module: ysyx_24110026_alu_arbiter
// PURPOSE
//  Shares the single combinational one-hot-opcode ALU between NREQ requesters
//  (e.g. EXU integer ops, LSU address generation). Each requester uses a valid/ready handshake.
//  A round-robin scheduler grants one requester at a time. The block registers the operands,
//  drives the ALU for one cycle and captures the result. It returns the result with a
//  requester ID on a valid/ready response channel that stalls when downstream is busy.
// PARAMETERS
//  NREQ  2   number of requesters (2..8)
//  DW    32  operand/result width
//  OPW   8   ALU opcode width (one-hot: add,sub,xor,or,and,srl,sll,sra = bit0..7)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-low reset
//  req_valid  in   NREQ       requester i has an op pending
//  req_ready  out  NREQ       requester i's op accepted this cycle
//  req_op     in   NREQ*OPW   opcode of requester i at [i*OPW +: OPW]
//  req_a      in   NREQ*DW    operand A of requester i at [i*DW +: DW]
//  req_b      in   NREQ*DW    operand B of requester i at [i*DW +: DW]
//  alu_op     out  OPW        opcode to ALU
//  alu_a      out  DW         operand A to ALU
//  alu_b      out  DW         operand B to ALU
//  alu_out    in   DW         ALU result (combinational from alu_*)
//  rsp_valid  out  1          response available
//  rsp_ready  in   1          downstream accepts response
//  rsp_data   out  DW         captured ALU result
//  rsp_id     out  clog2(NREQ) index of requester that owns rsp_data
//  rsp_err    out  1          captured op was not exactly one-hot (rsp_data is 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, rr_ptr=NREQ-1 so requester 0 has top priority,
//    req_ready=0, alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
//    An in-flight op is discarded and no response is produced for it.
//  - FSM states: IDLE -> ISSUE -> RESP -> IDLE. Exactly one op is in flight at any time.
//  - IDLE: if any req_valid, grant g = first set bit searching rr_ptr+1, rr_ptr+2, ...
//    modulo NREQ. req_ready[g]=1 combinationally in the same cycle; all other bits are 0.
//    On the edge: latch op/a/b of g, id=g, rr_ptr=g, go ISSUE. With no valid request, stay.
//  - req_ready is 0 in ISSUE and RESP. A requester must hold valid and payload stable until ready.
//  - ISSUE: alu_op/alu_a/alu_b driven from the latches (they are 0 in every other state).
//    On the edge: rsp_data=alu_out, rsp_id=id, rsp_err=(op==0 || op&(op-1)!=0),
//    rsp_valid=1, go RESP.
//  - RESP: rsp_valid=1 with rsp_data/rsp_id/rsp_err held stable. When rsp_ready=1,
//    rsp_valid clears on the edge and the FSM goes IDLE. No new grant happens in the same cycle.
//  - Latency: accept at cycle T gives rsp_valid at T+2. Minimum issue interval is 3 cycles.
//  - Fairness: a requester that keeps valid high is granted within NREQ grants.
//  - req_valid rising while the FSM is not in IDLE is ignored until the FSM returns to IDLE.
//  - Operands pass through unmodified. Width and shift semantics belong to the ALU.
// TESTING
//  1 reset mid-ISSUE (rst low 1 cycle) -> rsp_valid=0, state IDLE, next grant to req0.
//  2 req0 add a=5,b=7 alone, rsp_ready=1 -> req_ready[0] at T, rsp_valid T+2, data=12, id=0.
//  3 req0 and req1 both valid constantly, sub a=9,b=3 / xor a=F0,b=FF -> grants 0,1,0,1.
//    Responses: 6 (id0), 0F (id1), alternating.
//  4 rsp_ready=0 for 5 cycles after rsp_valid -> data/id stable, req_ready stays 0.
//    rsp_ready=1 -> IDLE the next cycle.
//  5 op=8'b00000011 -> rsp_err=1, rsp_data=0. op=0 -> rsp_err=1.
//    op=8'b00010000, a=FF00, b=0FF0 -> rsp_data=0F00, rsp_err=0.
//  6 only req1 valid after reset -> granted at first IDLE cycle, rr_ptr=1.
//    Then req0 and req1 both valid -> req0 is granted next.

Source files
------------

// File: rtl/ysyx_24110026_alu_arbiter.sv
// Round-robin share of one combinational one-hot-opcode ALU among NREQ valid/ready requesters.
// Accept at T gives rsp_valid at T+2; rsp_ready low holds the response and blocks any new grant.
module ysyx_24110026_alu_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OPW-1:0]      req_op,
  input  logic [NREQ*DW-1:0]       req_a,
  input  logic [NREQ*DW-1:0]       req_b,
  output logic [OPW-1:0]           alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [DW-1:0]            alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_vld;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic           op_err;

  // Walk from farthest to nearest so rr_ptr+1 ends up with the highest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && state == IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_op = (state == ISSUE) ? op_q : '0;
  assign alu_a  = (state == ISSUE) ? a_q  : '0;
  assign alu_b  = (state == ISSUE) ? b_q  : '0;

  // Zero or multi-hot opcodes are flagged and their ALU result is suppressed.
  assign op_err = (op_q == '0) || ((op_q & (op_q - OPW'(1))) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            rr_ptr <= grant_idx;
            id_q   <= grant_idx;
            op_q   <= req_op[int'(grant_idx)*OPW +: OPW];
            a_q    <= req_a[int'(grant_idx)*DW +: DW];
            b_q    <= req_b[int'(grant_idx)*DW +: DW];
          end
        end
        ISSUE: begin
          rsp_data  <= op_err ? '0 : alu_out;
          rsp_id    <= id_q;
          rsp_err   <= op_err;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110026_alu_arbiter.sv
// Directed bench for the ALU arbiter with a behavioural one-hot ALU attached.
module tb_ysyx_24110026_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  ysyx_24110026_alu_arbiter #(.NREQ(2), .DW(32), .OPW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      8'h01:   alu_out = alu_a + alu_b;
      8'h02:   alu_out = alu_a - alu_b;
      8'h04:   alu_out = alu_a ^ alu_b;
      8'h08:   alu_out = alu_a | alu_b;
      8'h10:   alu_out = alu_a & alu_b;
      8'h20:   alu_out = alu_a >> alu_b[4:0];
      8'h40:   alu_out = alu_a << alu_b[4:0];
      8'h80:   alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
  endtask

  task automatic do_op(input int r, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] d, output logic id,
                       output logic err, output bit to);
    int n;
    to = 1'b0; d = '0; id = 1'b0; err = 1'b0;
    req_op[r*8 +: 8]   = op;
    req_a[r*32 +: 32]  = a;
    req_b[r*32 +: 32]  = b;
    req_valid[r]       = 1'b1;
    rsp_ready          = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 10) begin cyc(); n++; end
    if (!req_ready[r]) begin to = 1'b1; req_valid[r] = 1'b0; return; end
    cyc();
    req_valid[r] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin cyc(); n++; end
    if (!rsp_valid) begin to = 1'b1; return; end
    d = rsp_data; id = rsp_id[0]; err = rsp_err;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    req_op = {8'h01, 8'h01};
    req_a = {32'd1, 32'd1};
    req_b = {32'd1, 32'd1};
    cyc();
    cyc();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b want=00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({rsp_data, rsp_id, rsp_err} !== 34'd0) begin bad++; $display("FAIL rst_rsp_fields got=%h/%h/%b want=0", rsp_data, rsp_id, rsp_err); end
    total++; if ({alu_op, alu_a, alu_b} !== 72'd0) begin bad++; $display("FAIL rst_alu got=%h/%h/%h want=0", alu_op, alu_a, alu_b); end
    rst = 1'b1;
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant got=%b want=01", req_ready); end
    cyc();
    total++; if (alu_op !== 8'h01) begin bad++; $display("FAIL issue_before_rst got=%h want=01", alu_op); end
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    total++; if (alu_op !== 8'h00 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_issue_rst got=%h/%b want=00/0", alu_op, rsp_valid); end
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL discarded_op got=%b want=0", rsp_valid); end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL post_rst_grant got=%b want=01", req_ready); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_op[7:0] = 8'h01; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL single_issue got=%b/%b want=0/00", rsp_valid, req_ready); end
    total++; if ({alu_op, alu_a, alu_b} !== {8'h01, 32'd5, 32'd7}) begin bad++; $display("FAIL single_alu got=%h/%h/%h want=01/5/7", alu_op, alu_a, alu_b); end
    cyc();
    total++; if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin bad++; $display("FAIL single_rsp got=%b/%h/%h/%b want=1/c/0/0", rsp_valid, rsp_data, rsp_id, rsp_err); end
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_done got=%b want=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    logic [1:0]  exp_g;
    apply_reset();
    req_op = {8'h04, 8'h02};
    req_a  = {32'hF0, 32'd9};
    req_b  = {32'hFF, 32'd3};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'd6 : 32'h0F;
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, req_ready, exp_g); end
      cyc();
      cyc();
      total++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d, exp_g[1]}) begin bad++; $display("FAIL rr_rsp%0d got=%b/%h/%h want=1/%h/%h", i, rsp_valid, rsp_data, rsp_id, exp_d, exp_g[1]); end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_op = {8'h01, 8'h10};
    req_a  = {32'd1, 32'd3};
    req_b  = {32'd1, 32'd6};
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b want=01", req_ready); end
    cyc();
    req_valid = 2'b10;
    cyc();
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 32'd2, 1'b0, 2'b00}) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%h/%b want=1/2/0/00", i, rsp_valid, rsp_data, rsp_id, req_ready); end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin bad++; $display("FAIL bp_release got=%b/%b want=1/00", rsp_valid, req_ready); end
    cyc();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin bad++; $display("FAIL bp_idle got=%b/%b want=0/10", rsp_valid, req_ready); end
  endtask

  task automatic test_onehot_err();
    logic [31:0] d;
    logic        id;
    logic        err;
    bit          to;
    apply_reset();
    do_op(0, 8'h03, 32'd1, 32'd2, d, id, err, to);
    total++; if (to || err !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL err_multihot got=%b/%h to=%b want=1/0", err, d, to); end
    do_op(0, 8'h00, 32'd5, 32'd5, d, id, err, to);
    total++; if (to || err !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL err_zero got=%b/%h to=%b want=1/0", err, d, to); end
    do_op(0, 8'h10, 32'hFF00, 32'h0FF0, d, id, err, to);
    total++; if (to || err !== 1'b0 || d !== 32'h0F00 || id !== 1'b0) begin bad++; $display("FAIL and_ok got=%b/%h/%b to=%b want=0/f00/0", err, d, id, to); end
    do_op(1, 8'h80, 32'h8000_0000, 32'd4, d, id, err, to);
    total++; if (to || err !== 1'b0 || d !== 32'hF800_0000 || id !== 1'b1) begin bad++; $display("FAIL sra_req1 got=%b/%h/%b to=%b want=0/f8000000/1", err, d, id, to); end
  endtask

  task automatic test_rr_start();
    apply_reset();
    req_op = {8'h08, 8'h01};
    req_a  = {32'h0F, 32'd1};
    req_b  = {32'hF0, 32'd1};
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL solo_req1 got=%b want=10", req_ready); end
    cyc();
    req_valid = 2'b00;
    cyc();
    total++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 32'hFF, 1'b1}) begin bad++; $display("FAIL solo_rsp got=%b/%h/%h want=1/ff/1", rsp_valid, rsp_data, rsp_id); end
    cyc();
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL after_req1 got=%b want=01", req_ready); end
    apply_reset();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_onehot_err();
    test_rr_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
